// File: rtl/priority_encoder_rr_if.sv
// Request/result bundle for priority_encoder_rr: the request side (req, mode)
// and the valid/ready result side, sized by the number of request lines N.
interface priority_encoder_rr_if #(
  parameter int N = 8
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic             mode;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;
  logic [IDX_W-1:0] rr_ptr;

  modport master (
    output req, mode, out_ready,
    input  out_valid, out_idx, out_onehot, rr_ptr
  );

  modport slave (
    input  req, mode, out_ready,
    output out_valid, out_idx, out_onehot, rr_ptr
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered N-way priority encoder with fixed (MSB-first) or round-robin
// arbitration; the winner is held under a valid/ready handshake.
module priority_encoder_rr #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input logic                   clk,
  input logic                   rst_n,
  priority_encoder_rr_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e           state_q;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     onehot_q;
  logic [IDX_W-1:0] rr_ptr_q;

  logic             accept_s;
  logic             req_any_s;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] fixed_idx_s;
  logic [IDX_W-1:0] rr_hi_idx_s;
  logic [IDX_W-1:0] rr_lo_idx_s;
  logic             rr_hi_found_s;
  logic             hi_hit_s;
  logic [IDX_W-1:0] idx_d;
  logic [N-1:0]     onehot_d;

  // Pointer advance on accept, then winner selection from the advanced pointer.
  always_comb begin
    accept_s      = valid_q & bus.out_ready;
    req_any_s     = |bus.req;
    fixed_idx_s   = {IDX_W{1'b0}};
    rr_hi_idx_s   = {IDX_W{1'b0}};
    rr_lo_idx_s   = {IDX_W{1'b0}};
    rr_hi_found_s = 1'b0;
    hi_hit_s      = 1'b0;
    onehot_d      = {N{1'b0}};

    if (accept_s && bus.mode) begin
      if (idx_q == LAST_IDX) begin
        rr_ptr_d = {IDX_W{1'b0}};
      end else begin
        rr_ptr_d = idx_q + 1'b1;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    for (int k = 0; k < N; k++) begin
      fixed_idx_s = bus.req[k] ? IDX_W'(k) : fixed_idx_s;
    end

    // Descending scan leaves the lowest set index at/above the pointer in
    // rr_hi and the lowest set index overall (the wrap-around pick) in rr_lo.
    for (int k = N - 1; k >= 0; k--) begin
      hi_hit_s      = bus.req[k] && (k >= int'(rr_ptr_d));
      rr_hi_idx_s   = hi_hit_s ? IDX_W'(k) : rr_hi_idx_s;
      rr_hi_found_s = rr_hi_found_s | hi_hit_s;
      rr_lo_idx_s   = bus.req[k] ? IDX_W'(k) : rr_lo_idx_s;
    end

    if (bus.mode) begin
      idx_d = rr_hi_found_s ? rr_hi_idx_s : rr_lo_idx_s;
    end else begin
      idx_d = fixed_idx_s;
    end

    for (int k = 0; k < N; k++) begin
      onehot_d[k] = (idx_d == IDX_W'(k));
    end
  end

  // IDLE/HOLD control with registered result, valid and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      idx_q    <= {IDX_W{1'b0}};
      onehot_q <= {N{1'b0}};
      rr_ptr_q <= {IDX_W{1'b0}};
    end else begin
      rr_ptr_q <= rr_ptr_d;
      case (state_q)
        IDLE: begin
          if (req_any_s) begin
            state_q  <= HOLD;
            valid_q  <= 1'b1;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
          end else begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (accept_s) begin
            if (req_any_s) begin
              state_q  <= HOLD;
              valid_q  <= 1'b1;
              idx_q    <= idx_d;
              onehot_q <= onehot_d;
            end else begin
              // out_idx deliberately keeps the last winner.
              state_q  <= IDLE;
              valid_q  <= 1'b0;
              onehot_q <= {N{1'b0}};
            end
          end else begin
            state_q  <= HOLD;
            valid_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          onehot_q <= {N{1'b0}};
        end
      endcase
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.rr_ptr     = rr_ptr_q;

endmodule
